// File: rtl/decode_stage_if.sv
// Fetch/execute handshake bundle around decode_stage.
// slave = the decode stage, master = its fetch/execute neighbours.
interface decode_stage_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instr;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_is_imm;
  logic        ex_illegal;

  modport slave (
    input  if_valid, if_instr, ex_ready,
    output if_ready, ex_valid, ex_instr,
    output ex_in1, ex_in2, ex_imm,
    output ex_rd, ex_is_imm, ex_illegal
  );

  modport master (
    output if_valid, if_instr, ex_ready,
    input  if_ready, ex_valid, ex_instr,
    input  ex_in1, ex_in2, ex_imm,
    input  ex_rd, ex_is_imm, ex_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: regfile, I/R-type operand fetch, one-entry output.
// Define DECODE_STAGE_RF_BYPASS_EN for write-before-read on accept.
module decode_stage #(
  parameter logic [31:0] RF_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        is_imm;
    logic        illegal;
  } id_ex_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic [31:0] rf [0:31];
  id_ex_t      q;

  logic        wb_hit;
  logic        accept;
  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        is_i;
  logic        is_r;
  logic        is_sh;
  logic [31:0] d_in1;
  logic [31:0] d_in2;
  logic [31:0] d_imm;
  logic        d_is_imm;
  logic        d_ill;
  logic        hz1;
  logic        hz2;

  assign wb_hit = wb_en && (wb_rd != 5'd0);

  assign bus.if_ready = (!q.valid || bus.ex_ready) && !flush;
  assign accept       = bus.if_valid && bus.if_ready;

  assign instr = bus.if_instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign is_i  = (opc == OP_IMM);
  assign is_r  = (opc == OP_REG);
  assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);

  function automatic logic [31:0] rd_reg(
    input logic [4:0] a
  );
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : rf[a];
`ifdef DECODE_STAGE_RF_BYPASS_EN
    if (wb_hit && (wb_rd == a))
      v = wb_data;
`endif
    return v;
  endfunction

  always_comb begin
    d_in1    = rd_reg(rs1);
    d_in2    = '0;
    d_imm    = '0;
    d_is_imm = 1'b0;
    d_ill    = 1'b0;
    unique case (1'b1)
      is_i: begin
        d_is_imm = 1'b1;
        // shifts carry shamt, not a signed immediate
        d_imm = is_sh ? {27'b0, instr[24:20]}
                      : {{20{instr[31]}}, instr[31:20]};
      end
      is_r: d_in2 = rd_reg(rs2);
      default: d_ill = 1'b1;
    endcase
  end

  // forward write-back into a stalled entry so it never goes stale
  assign hz1 = wb_hit && (wb_rd == q.instr[19:15]);
  assign hz2 = wb_hit && !q.is_imm && !q.illegal
             && (wb_rd == q.instr[24:20]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= RF_INIT;
    end else if (wb_hit) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (accept) begin
      q.valid   <= 1'b1;
      q.instr   <= instr;
      q.in1     <= d_in1;
      q.in2     <= d_in2;
      q.imm     <= d_imm;
      q.rd      <= instr[11:7];
      q.is_imm  <= d_is_imm;
      q.illegal <= d_ill;
    end else if (q.valid && bus.ex_ready) begin
      q.valid <= 1'b0;
    end else if (q.valid) begin
      if (hz1) q.in1 <= wb_data;
      if (hz2) q.in2 <= wb_data;
    end
  end

  assign bus.ex_valid   = q.valid;
  assign bus.ex_instr   = q.instr;
  assign bus.ex_in1     = q.in1;
  assign bus.ex_in2     = q.in2;
  assign bus.ex_imm     = q.imm;
  assign bus.ex_rd      = q.rd;
  assign bus.ex_is_imm  = q.is_imm;
  assign bus.ex_illegal = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage with an expected-entry queue.
// Build with DECODE_STAGE_RF_BYPASS_EN to check the bypass variant.
module tb_decode_stage;

  localparam logic [31:0] RFI = 32'h1234_5678;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        is_imm;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int   passed = 0;
  int   total  = 0;
  exp_t sbq[$];

  decode_stage_if bus();

  decode_stage #(.RF_INIT(RFI)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t obs();
    return '{bus.ex_instr, bus.ex_in1, bus.ex_in2,
             bus.ex_imm, bus.ex_rd, bus.ex_is_imm,
             bus.ex_illegal};
  endfunction

  function automatic exp_t mk(
    input logic [31:0] i, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] m,
    input logic [4:0] r, input logic ii,
    input logic il);
    return '{i, a, b, m, r, ii, il};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r,
                    input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'hFFF00093;
    bus.ex_ready = 1'b0;
    tick(); tick();
    o = obs();
    total++;
    if (bus.ex_valid !== 1'b0 || o !== '0) begin
      $display("FAIL reset_outputs: got v=%b %h want all 0",
               bus.ex_valid, o);
    end else passed++;
    total++;
    if (bus.if_ready !== 1'b1)
      $display("FAIL reset_if_ready: got %b want 1", bus.if_ready);
    else passed++;
    rst_n = 1'b1;
    bus.if_valid = 1'b0;
    tick();
    total++;
    if (bus.ex_valid !== 1'b0)
      $display("FAIL reset_no_accept: got %b want 0", bus.ex_valid);
    else passed++;
  endtask

  task automatic test_addi();
    exp_t e;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'hFFF00093;
    bus.ex_ready = 1'b1;
    sbq.push_back(mk(32'hFFF00093, 0, 0, 32'hFFFFFFFF,
                     5'd1, 1'b1, 1'b0));
    tick();
    bus.if_valid = 1'b0;
    e = sbq.pop_front();
    total++;
    if (bus.ex_valid !== 1'b1 || obs() !== e)
      $display("FAIL addi: got v=%b %h want v=1 %h",
               bus.ex_valid, obs(), e);
    else passed++;
    tick();
    total++;
    if (bus.ex_valid !== 1'b0)
      $display("FAIL addi_drain: got %b want 0", bus.ex_valid);
    else passed++;
  endtask

  task automatic test_srai();
    exp_t e;
    wb(5'd2, 32'h80000000);
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h40315093;
    sbq.push_back(mk(32'h40315093, 32'h80000000, 0,
                     32'h3, 5'd1, 1'b1, 1'b0));
    tick();
    bus.if_valid = 1'b0;
    e = sbq.pop_front();
    total++;
    if (bus.ex_valid !== 1'b1 || obs() !== e
        || bus.ex_instr[30] !== 1'b1)
      $display("FAIL srai: got v=%b %h want v=1 %h",
               bus.ex_valid, obs(), e);
    else passed++;
    tick();
  endtask

  task automatic test_stall();
    exp_t e;
    wb(5'd5, 32'd7);
    wb(5'd6, 32'd9);
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h006282B3;
    sbq.push_back(mk(32'h006282B3, 32'd7, 32'd9, 0,
                     5'd5, 1'b0, 1'b0));
    tick();
    bus.if_instr = 32'h00500393;
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'd1;
    #1;
    total++;
    if (bus.if_ready !== 1'b0 || obs() !== sbq[0])
      $display("FAIL stall_enter: got rdy=%b %h want rdy=0 %h",
               bus.if_ready, obs(), sbq[0]);
    else passed++;
    sbq[0].in2 = 32'd1;
    for (int c = 0; c < 2; c++) begin
      tick();
      wb_en = 1'b0;
      total++;
      if (bus.ex_valid !== 1'b1 || bus.if_ready !== 1'b0
          || obs() !== sbq[0])
        $display("FAIL stall_hold%0d: got v=%b rdy=%b %h want %h",
                 c, bus.ex_valid, bus.if_ready, obs(), sbq[0]);
      else passed++;
    end
    bus.ex_ready = 1'b1;
    #1;
    total++;
    if (bus.if_ready !== 1'b1)
      $display("FAIL stall_release: got %b want 1", bus.if_ready);
    else passed++;
    void'(sbq.pop_front());
    sbq.push_back(mk(32'h00500393, 0, 0, 32'd5,
                     5'd7, 1'b1, 1'b0));
    tick();
    bus.if_valid = 1'b0;
    e = sbq.pop_front();
    total++;
    if (bus.ex_valid !== 1'b1 || obs() !== e)
      $display("FAIL stall_replace: got v=%b %h want %h",
               bus.ex_valid, obs(), e);
    else passed++;
    tick();
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [31:0] want;
`ifdef DECODE_STAGE_RF_BYPASS_EN
    want = 32'h55;
`else
    want = RFI;
`endif
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h00018213;
    sbq.push_back(mk(32'h00018213, want, 0, 0,
                     5'd4, 1'b1, 1'b0));
    tick();
    wb_en = 1'b0;
    bus.if_valid = 1'b0;
    e = sbq.pop_front();
    total++;
    if (bus.ex_valid !== 1'b1 || obs() !== e)
      $display("FAIL bypass: got %h want %h", obs(), e);
    else passed++;
    tick();
  endtask

  task automatic test_flush_illegal();
    exp_t e;
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h0000007F;
    sbq.push_back(mk(32'h0000007F, 0, 0, 0,
                     5'd0, 1'b0, 1'b1));
    tick();
    e = sbq.pop_front();
    total++;
    if (bus.ex_valid !== 1'b1 || obs() !== e)
      $display("FAIL illegal: got v=%b %h want v=1 %h",
               bus.ex_valid, obs(), e);
    else passed++;
    flush = 1'b1;
    bus.ex_ready = 1'b1;
    bus.if_instr = 32'h00500393;
    #1;
    total++;
    if (bus.if_ready !== 1'b0)
      $display("FAIL flush_ready: got %b want 0", bus.if_ready);
    else passed++;
    tick();
    flush = 1'b0;
    bus.if_valid = 1'b0;
    total++;
    if (bus.ex_valid !== 1'b0)
      $display("FAIL flush_clear: got %b want 0", bus.ex_valid);
    else passed++;
    wb(5'd0, 32'hDEADBEEF);
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h00000433;
    sbq.push_back(mk(32'h00000433, 0, 0, 0,
                     5'd8, 1'b0, 1'b0));
    tick();
    bus.if_valid = 1'b0;
    e = sbq.pop_front();
    total++;
    if (bus.ex_valid !== 1'b1 || obs() !== e)
      $display("FAIL x0_read: got %h want %h", obs(), e);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] imms [4];
    logic [31:0] ins;
    logic [4:0]  r;
    exp_t        e;
    imms = '{12'h001, 12'h7FF, 12'h800, 12'hFFF};
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r = 5'(10 + i);
      ins = {imms[i], 5'd2, 3'b000, r, 7'h13};
      bus.if_valid = 1'b1;
      bus.if_instr = ins;
      sbq.push_back(mk(ins, 32'h80000000, 0,
                       {{20{imms[i][11]}}, imms[i]},
                       r, 1'b1, 1'b0));
      tick();
      e = sbq.pop_front();
      total++;
      if (bus.ex_valid !== 1'b1 || obs() !== e)
        $display("FAIL b2b_%0d: got v=%b %h want v=1 %h",
                 i, bus.ex_valid, obs(), e);
      else passed++;
    end
    bus.if_valid = 1'b0;
    tick();
    total++;
    if (bus.ex_valid !== 1'b0)
      $display("FAIL b2b_drain: got %b want 0", bus.ex_valid);
    else passed++;
  endtask

  task automatic test_reset_midstall();
    exp_t e;
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h00500393;
    tick();
    bus.if_valid = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hAA;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.ex_valid !== 1'b0 || bus.ex_instr !== 32'd0)
      $display("FAIL midstall_rst: got v=%b i=%h want 0 0",
               bus.ex_valid, bus.ex_instr);
    else passed++;
    tick();
    wb_en = 1'b0;
    rst_n = 1'b1;
    bus.ex_ready = 1'b1;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h00048513;
    sbq.push_back(mk(32'h00048513, RFI, 0, 0,
                     5'd10, 1'b1, 1'b0));
    tick();
    bus.if_valid = 1'b0;
    e = sbq.pop_front();
    total++;
    if (bus.ex_valid !== 1'b1 || obs() !== e)
      $display("FAIL midstall_wb_lost: got %h want %h", obs(), e);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_srai();
    test_stall();
    test_bypass();
    test_flush_illegal();
    test_back_to_back();
    test_reset_midstall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
